ysyx_rob_lite: RTL and testbench

- In-order reorder buffer. Sits between IDU dispatch (idu_pipe_if producer side) and EXU writeback (exu_pipe_if producer side); it consumes both and is the far end of each.
- Allocates ROB tags (dest) at dispatch, captures out-of-order EXU results, and retires one instruction per cycle in program order to the WBU/regfile.
- Raises a flush on a mispredicted npc or a trap at the head.

---
 rtl/ysyx_rob_pkg.sv | 36 +++
 rtl/ysyx_rob_lite.sv | 148 ++++++++++++++
 tb/tb_ysyx_rob_lite.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_rob_pkg.sv
// Shared types, sizing and tag helpers for the ysyx in-order reorder buffer.
// A tag is {phase, index}; the phase bit toggles each time a pointer wraps.
package ysyx_rob_pkg;

  localparam int unsigned XLEN = 32;

  localparam int unsigned ROB_SIZE = 8;
  localparam int unsigned TW       = $clog2(ROB_SIZE) + 1;
  localparam int unsigned IW       = TW - 1;

  typedef logic [TW-1:0] tag_t;
  typedef logic [IW-1:0] idx_t;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            phase;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pnpc;
    logic [XLEN-1:0] npc;
    logic [31:0]     inst;
    logic [XLEN-1:0] result;
    logic            trap;
    logic [XLEN-1:0] cause;
  } rob_entry_t;

  function automatic idx_t idx_of(input tag_t tag);
    return tag[IW-1:0];
  endfunction

  function automatic logic phase_of(input tag_t tag);
    return tag[TW-1];
  endfunction

endpackage

// File: rtl/ysyx_rob_lite.sv
// In-order reorder buffer: allocates tags at dispatch, captures out-of-order
// writebacks, retires in order and flushes on mispredict/trap. Optional
// same-cycle writeback-to-commit bypass: define YSYX_ROB_WB_BYPASS_EN.
module ysyx_rob_lite
   import ysyx_rob_pkg::*;
(
   input  logic            clock,
   input  logic            reset,

   input  logic            disp_valid,
   output logic            disp_ready,
   input  logic [4:0]      disp_rd,
   input  logic [XLEN-1:0] disp_pc,
   input  logic [XLEN-1:0] disp_pnpc,
   input  logic [31:0]     disp_inst,
   input  logic            disp_trap,
   input  logic [XLEN-1:0] disp_cause,
   output logic [TW-1:0]   disp_dest,

   input  logic            wb_valid,
   input  logic [TW-1:0]   wb_dest,
   input  logic [XLEN-1:0] wb_result,
   input  logic [XLEN-1:0] wb_npc,
   input  logic            wb_trap,
   input  logic [XLEN-1:0] wb_cause,

   output logic            cmt_valid,
   input  logic            cmt_ready,
   output logic [4:0]      cmt_rd,
   output logic [XLEN-1:0] cmt_result,
   output logic [XLEN-1:0] cmt_pc,
   output logic [XLEN-1:0] cmt_npc,
   output logic [31:0]     cmt_inst,
   output logic            cmt_trap,
   output logic [XLEN-1:0] cmt_cause,

   output logic            flush,
   output logic [XLEN-1:0] flush_pc,
   output logic            empty
);

   rob_entry_t rob [ROB_SIZE];
   tag_t       head;
   tag_t       tail;

   idx_t head_idx;
   idx_t tail_idx;
   idx_t wb_idx;
   logic full;
   logic disp_fire;
   logic wb_accept;
   logic retire;
   logic flush_cond;

   assign head_idx = idx_of(head);
   assign tail_idx = idx_of(tail);
   assign wb_idx   = idx_of(wb_dest);

   assign full       = (head_idx == tail_idx) && (phase_of(head) != phase_of(tail));
   assign empty      = (head == tail);
   assign disp_ready = !full && !flush;
   assign disp_fire  = disp_valid && disp_ready;
   assign disp_dest  = tail;

   // Stale tags (flushed or already reused with the other phase) fall out here.
   assign wb_accept = wb_valid && !flush
                      && rob[wb_idx].busy
                      && (rob[wb_idx].phase == phase_of(wb_dest))
                      && !rob[wb_idx].done;

   always_comb begin
      cmt_valid  = rob[head_idx].busy && rob[head_idx].done && !flush;
      cmt_rd     = rob[head_idx].rd;
      cmt_pc     = rob[head_idx].pc;
      cmt_inst   = rob[head_idx].inst;
      cmt_result = rob[head_idx].result;
      cmt_npc    = rob[head_idx].npc;
      cmt_trap   = rob[head_idx].trap;
      cmt_cause  = rob[head_idx].cause;
`ifdef YSYX_ROB_WB_BYPASS_EN
      if (wb_accept && (wb_idx == head_idx)) begin
         cmt_valid  = 1'b1;
         cmt_result = wb_result;
         cmt_npc    = wb_npc;
         cmt_trap   = wb_trap;
         cmt_cause  = wb_cause;
      end
`endif
   end

   assign retire     = cmt_valid && cmt_ready;
   assign flush_cond = retire && (cmt_trap || (cmt_npc != rob[head_idx].pnpc));

   // Later assignments win: flush clear > retire > writeback > dispatch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head     <= '0;
         tail     <= '0;
         flush    <= 1'b0;
         flush_pc <= '0;
         for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            rob[i] <= '0;
         end
      end else begin
         flush <= flush_cond;
         if (flush_cond) begin
            flush_pc <= cmt_trap ? cmt_pc : cmt_npc;
         end

         if (disp_fire) begin
            rob[tail_idx] <= '{busy:   1'b1,
                               done:   disp_trap,
                               phase:  phase_of(tail),
                               rd:     disp_rd,
                               pc:     disp_pc,
                               pnpc:   disp_pnpc,
                               npc:    disp_pnpc,
                               inst:   disp_inst,
                               result: '0,
                               trap:   disp_trap,
                               cause:  disp_trap ? disp_cause : '0};
            tail <= tail + tag_t'(1);
         end

         if (wb_accept) begin
            rob[wb_idx].done   <= 1'b1;
            rob[wb_idx].result <= wb_result;
            rob[wb_idx].npc    <= wb_npc;
            rob[wb_idx].trap   <= wb_trap;
            rob[wb_idx].cause  <= wb_cause;
         end

         if (retire) begin
            rob[head_idx].busy <= 1'b0;
            head               <= head + tag_t'(1);
         end

         // Everything younger than the retiring head is discarded.
         if (flush_cond) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
               rob[i].busy <= 1'b0;
            end
            tail <= head + tag_t'(1);
         end
      end
   end

endmodule

// File: tb/tb_ysyx_rob_lite.sv
// Self-checking bench for ysyx_rob_lite: directed scenarios plus randomized
// traffic compared against a program-order queue model of the buffer.
module tb_ysyx_rob_lite;
   import ysyx_rob_pkg::*;

`ifdef YSYX_ROB_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            disp_valid = 1'b0;
   logic            disp_ready;
   logic [4:0]      disp_rd = '0;
   logic [XLEN-1:0] disp_pc = '0;
   logic [XLEN-1:0] disp_pnpc = '0;
   logic [31:0]     disp_inst = '0;
   logic            disp_trap = 1'b0;
   logic [XLEN-1:0] disp_cause = '0;
   logic [TW-1:0]   disp_dest;
   logic            wb_valid = 1'b0;
   logic [TW-1:0]   wb_dest = '0;
   logic [XLEN-1:0] wb_result = '0;
   logic [XLEN-1:0] wb_npc = '0;
   logic            wb_trap = 1'b0;
   logic [XLEN-1:0] wb_cause = '0;
   logic            cmt_valid;
   logic            cmt_ready = 1'b0;
   logic [4:0]      cmt_rd;
   logic [XLEN-1:0] cmt_result;
   logic [XLEN-1:0] cmt_pc;
   logic [XLEN-1:0] cmt_npc;
   logic [31:0]     cmt_inst;
   logic            cmt_trap;
   logic [XLEN-1:0] cmt_cause;
   logic            flush;
   logic [XLEN-1:0] flush_pc;
   logic            empty;

   always #5 clock = ~clock;

   ysyx_rob_lite dut (
      .clock(clock), .reset(reset),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
      .disp_pc(disp_pc), .disp_pnpc(disp_pnpc), .disp_inst(disp_inst),
      .disp_trap(disp_trap), .disp_cause(disp_cause), .disp_dest(disp_dest),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result),
      .wb_npc(wb_npc), .wb_trap(wb_trap), .wb_cause(wb_cause),
      .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_rd(cmt_rd),
      .cmt_result(cmt_result), .cmt_pc(cmt_pc), .cmt_npc(cmt_npc),
      .cmt_inst(cmt_inst), .cmt_trap(cmt_trap), .cmt_cause(cmt_cause),
      .flush(flush), .flush_pc(flush_pc), .empty(empty)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: in-flight instructions in program order.
   typedef struct {
      tag_t            tag;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc, pnpc, npc, result, cause;
      logic [31:0]     inst;
      bit              trap;
      bit              done;
      bit              wbd;
   } ment_t;

   ment_t           mq[$];
   tag_t            m_tail;
   bit              m_flush;
   logic [XLEN-1:0] m_flush_pc;

   task automatic model_reset();
      mq.delete();
      m_tail     = '0;
      m_flush    = 1'b0;
      m_flush_pc = '0;
   endtask

   function automatic int find_live(input tag_t t);
      foreach (mq[j]) if (mq[j].tag == t && !mq[j].done) return j;
      return -1;
   endfunction

   function automatic bit m_hit_head();
      return BYPASS && wb_valid && !m_flush && mq.size() > 0
             && !mq[0].done && wb_dest == mq[0].tag;
   endfunction

   function automatic bit m_cmt_valid();
      return !m_flush && mq.size() > 0 && (mq[0].done || m_hit_head());
   endfunction

   function automatic ment_t m_head_view();
      ment_t h;
      h = mq[0];
      if (m_hit_head()) begin
         h.result = wb_result; h.npc = wb_npc; h.trap = wb_trap;
         h.cause = wb_cause; h.wbd = 1'b1;
      end
      return h;
   endfunction

   task automatic model_clock();
      bit    cv, ret, fl, dfire;
      int    k;
      ment_t h, e;
      cv    = m_cmt_valid();
      if (cv) h = m_head_view();
      ret   = cv && cmt_ready;
      fl    = ret && (h.trap || h.npc != h.pnpc);
      dfire = disp_valid && mq.size() < ROB_SIZE && !m_flush;
      k     = (wb_valid && !m_flush) ? find_live(wb_dest) : -1;
      if (k >= 0) begin
         mq[k].done = 1'b1; mq[k].wbd = 1'b1; mq[k].result = wb_result;
         mq[k].npc = wb_npc; mq[k].trap = wb_trap; mq[k].cause = wb_cause;
      end
      if (ret) void'(mq.pop_front());
      if (fl) begin
         mq.delete();
         m_tail     = h.tag + tag_t'(1);
         m_flush    = 1'b1;
         m_flush_pc = h.trap ? h.pc : h.npc;
      end else begin
         m_flush = 1'b0;
         if (dfire) begin
            e.tag = m_tail; e.rd = disp_rd; e.pc = disp_pc; e.pnpc = disp_pnpc;
            e.npc = disp_pnpc; e.result = '0; e.inst = disp_inst;
            e.trap = disp_trap; e.cause = disp_trap ? disp_cause : '0;
            e.done = disp_trap; e.wbd = 1'b0;
            mq.push_back(e);
            m_tail = m_tail + tag_t'(1);
         end
      end
   endtask

   task automatic advance();
      @(posedge clock);
      model_clock();
      #1;
   endtask

   task automatic idle_inputs();
      disp_valid = 1'b0; disp_trap = 1'b0; wb_valid = 1'b0; cmt_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      advance();
   endtask

   task automatic drive_disp(input logic [XLEN-1:0] pc, input logic [4:0] rd);
      disp_valid = 1'b1; disp_rd = rd; disp_pc = pc; disp_pnpc = pc + 4;
      disp_inst = $urandom; disp_trap = 1'b0; disp_cause = '0;
   endtask

   task automatic drive_wb(input tag_t t, input logic [XLEN-1:0] res, input logic [XLEN-1:0] npc);
      wb_valid = 1'b1; wb_dest = t; wb_result = res; wb_npc = npc;
      wb_trap = 1'b0; wb_cause = '0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      #1;
      n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
      n_tests++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready: got %b expected 1", disp_ready); end
      n_tests++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmt_valid: got %b expected 0", cmt_valid); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", flush); end
      n_tests++; if (flush_pc !== '0) begin n_fail++; $display("FAIL reset_flush_pc: got %h expected 0", flush_pc); end
      n_tests++; if (disp_dest !== '0) begin n_fail++; $display("FAIL reset_disp_dest: got %h expected 0", disp_dest); end
      do_reset();
   endtask

   task automatic test_fill_empty();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive_disp(32'h8000_0000 + 32'(4 * i), 5'(i + 1));
         @(negedge clock);
         n_tests++; if (disp_dest !== tag_t'(i)) begin n_fail++; $display("FAIL fill_dest[%0d]: got %h expected %h", i, disp_dest, tag_t'(i)); end
         n_tests++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, disp_ready); end
         advance();
      end
      disp_valid = 1'b0;
      @(negedge clock);
      n_tests++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", disp_ready); end
      n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", empty); end
      n_tests++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL full_cmt_valid: got %b expected 0", cmt_valid); end
      advance();
      for (int i = 7; i >= 0; i--) begin
         drive_wb(tag_t'(i), 32'h1000 + 32'(i), 32'h8000_0004 + 32'(4 * i));
         @(negedge clock);
         n_tests++; if (cmt_valid !== (BYPASS && i == 0)) begin n_fail++; $display("FAIL rev_wb_cmt_valid[%0d]: got %b expected %b", i, cmt_valid, BYPASS && i == 0); end
         advance();
      end
      wb_valid  = 1'b0;
      cmt_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         n_tests++; if (cmt_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b expected 1", k, cmt_valid); end
         n_tests++; if (cmt_pc !== 32'h8000_0000 + 32'(4 * k)) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h expected %h", k, cmt_pc, 32'h8000_0000 + 32'(4 * k)); end
         n_tests++; if (cmt_result !== 32'h1000 + 32'(k)) begin n_fail++; $display("FAIL drain_result[%0d]: got %h expected %h", k, cmt_result, 32'h1000 + 32'(k)); end
         n_tests++; if (cmt_rd !== 5'(k + 1)) begin n_fail++; $display("FAIL drain_rd[%0d]: got %0d expected %0d", k, cmt_rd, k + 1); end
         advance();
      end
      cmt_ready = 1'b0;
      @(negedge clock);
      n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drained_empty: got %b expected 1", empty); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL drained_flush: got %b expected 0", flush); end
      advance();
   endtask

   task automatic test_wrap();
      logic [XLEN-1:0] pc;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         pc = 32'h8000_1000 + 32'(4 * i);
         drive_disp(pc, 5'(i + 1));
         @(negedge clock);
         n_tests++; if (disp_dest !== {1'(i >= 8), idx_t'(i % 8)}) begin n_fail++; $display("FAIL wrap_dest[%0d]: got %h expected %h", i, disp_dest, {1'(i >= 8), idx_t'(i % 8)}); end
         advance();
         disp_valid = 1'b0;
         if (i == 8) begin
            drive_wb(tag_t'(0), 32'hdead, pc + 4);
            @(negedge clock);
            n_tests++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL stale_wb_same: got %b expected 0", cmt_valid); end
            advance();
            wb_valid = 1'b0;
            @(negedge clock);
            n_tests++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL stale_wb_after: got %b expected 0", cmt_valid); end
            advance();
         end
         drive_wb(tag_t'(i), 32'(i), pc + 4);
         advance();
         wb_valid  = 1'b0;
         cmt_ready = 1'b1;
         @(negedge clock);
         n_tests++; if (cmt_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_cmt_valid[%0d]: got %b expected 1", i, cmt_valid); end
         n_tests++; if (cmt_pc !== pc) begin n_fail++; $display("FAIL wrap_cmt_pc[%0d]: got %h expected %h", i, cmt_pc, pc); end
         n_tests++; if (cmt_result !== 32'(i)) begin n_fail++; $display("FAIL wrap_cmt_result[%0d]: got %h expected %h", i, cmt_result, 32'(i)); end
         advance();
         cmt_ready = 1'b0;
      end
   endtask

   task automatic test_mispredict();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_disp(32'h8000_0004 + 32'(4 * i), 5'(i + 3));
         advance();
      end
      disp_valid = 1'b0;
      drive_wb(tag_t'(0), 32'h55, 32'h8000_0020);
      advance();
      wb_valid  = 1'b0;
      cmt_ready = 1'b1;
      @(negedge clock);
      n_tests++; if (cmt_valid !== 1'b1) begin n_fail++; $display("FAIL mp_cmt_valid: got %b expected 1", cmt_valid); end
      n_tests++; if (cmt_npc !== 32'h8000_0020) begin n_fail++; $display("FAIL mp_cmt_npc: got %h expected 80000020", cmt_npc); end
      advance();
      drive_wb(tag_t'(1), 32'h66, 32'h8000_000c);
      @(negedge clock);
      n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL mp_flush: got %b expected 1", flush); end
      n_tests++; if (flush_pc !== 32'h8000_0020) begin n_fail++; $display("FAIL mp_flush_pc: got %h expected 80000020", flush_pc); end
      n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mp_empty: got %b expected 1", empty); end
      n_tests++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL mp_cmt_blocked: got %b expected 0", cmt_valid); end
      n_tests++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL mp_disp_blocked: got %b expected 0", disp_ready); end
      advance();
      drive_wb(tag_t'(2), 32'h77, 32'h8000_0010);
      @(negedge clock);
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL mp_flush_pulse: got %b expected 0", flush); end
      n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mp_late_wb_empty: got %b expected 1", empty); end
      n_tests++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL mp_late_wb_cmt: got %b expected 0", cmt_valid); end
      n_tests++; if (disp_dest !== tag_t'(1)) begin n_fail++; $display("FAIL mp_tail: got %h expected 1", disp_dest); end
      advance();
      idle_inputs();
      @(negedge clock);
      n_tests++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL mp_after_cmt: got %b expected 0", cmt_valid); end
      advance();
   endtask

   task automatic test_trap_dispatch();
      do_reset();
      drive_disp(32'h8000_0100, 5'd7);
      disp_trap  = 1'b1;
      disp_cause = 32'd2;
      advance();
      idle_inputs();
      cmt_ready = 1'b1;
      @(negedge clock);
      n_tests++; if (cmt_valid !== 1'b1) begin n_fail++; $display("FAIL trap_cmt_valid: got %b expected 1", cmt_valid); end
      n_tests++; if (cmt_trap !== 1'b1) begin n_fail++; $display("FAIL trap_cmt_trap: got %b expected 1", cmt_trap); end
      n_tests++; if (cmt_cause !== 32'd2) begin n_fail++; $display("FAIL trap_cmt_cause: got %h expected 2", cmt_cause); end
      n_tests++; if (cmt_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL trap_cmt_pc: got %h expected 80000100", cmt_pc); end
      advance();
      @(negedge clock);
      n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL trap_flush: got %b expected 1", flush); end
      n_tests++; if (flush_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL trap_flush_pc: got %h expected 80000100", flush_pc); end
      advance();
      cmt_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive_disp(32'h8000_2000 + 32'(4 * i), 5'(i + 1));
         advance();
      end
      disp_valid = 1'b0;
      drive_wb(tag_t'(0), 32'h99, 32'h8000_2004);
      advance();
      wb_valid  = 1'b0;
      cmt_ready = 1'b1;
      drive_disp(32'h8000_2020, 5'd9);
      @(negedge clock);
      n_tests++; if (cmt_valid !== 1'b1) begin n_fail++; $display("FAIL simul_cmt_valid: got %b expected 1", cmt_valid); end
      n_tests++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL simul_ready_blocked: got %b expected 0", disp_ready); end
      advance();
      cmt_ready = 1'b0;
      @(negedge clock);
      n_tests++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready_next: got %b expected 1", disp_ready); end
      n_tests++; if (disp_dest !== tag_t'(8)) begin n_fail++; $display("FAIL simul_dest_next: got %h expected 8", disp_dest); end
      advance();
      disp_valid = 1'b0;
      @(negedge clock);
      n_tests++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL simul_full_again: got %b expected 0", disp_ready); end
      advance();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_disp(32'h8000_3000 + 32'(4 * i), 5'(i + 1));
         advance();
      end
      disp_valid = 1'b0;
      drive_wb(tag_t'(0), 32'h1, 32'h8000_3004);
      advance();
      wb_valid = 1'b0;
      @(negedge clock);
      n_tests++; if (cmt_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_cmt: got %b expected 1", cmt_valid); end
      #1 reset = 1'b0;
      #1;
      n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rmid_empty: got %b expected 1", empty); end
      n_tests++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_cmt_valid: got %b expected 0", cmt_valid); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: got %b expected 0", flush); end
      n_tests++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", disp_ready); end
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      advance();
      drive_disp(32'h8000_4000, 5'd1);
      @(negedge clock);
      n_tests++; if (disp_dest !== tag_t'(0)) begin n_fail++; $display("FAIL rmid_first_tag: got %h expected 0", disp_dest); end
      advance();
      disp_valid = 1'b0;
   endtask

   task automatic test_random(input int cycles);
      int    cand[$];
      int    j;
      bit    exp_cv;
      ment_t h;
      do_reset();
      for (int c = 0; c < cycles; c++) begin
         disp_valid = ($urandom_range(0, 3) != 0);
         disp_rd    = 5'($urandom);
         disp_pc    = $urandom & ~32'h3;
         disp_pnpc  = disp_pc + 4;
         disp_inst  = $urandom;
         disp_trap  = ($urandom_range(0, 31) == 0);
         disp_cause = $urandom;
         cand.delete();
         foreach (mq[k]) if (!mq[k].done) cand.push_back(k);
         wb_valid  = 1'b0;
         wb_result = $urandom;
         wb_cause  = $urandom;
         wb_trap   = 1'b0;
         if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
            j        = cand[$urandom_range(0, cand.size() - 1)];
            wb_valid = 1'b1;
            wb_dest  = mq[j].tag;
            wb_npc   = ($urandom_range(0, 15) == 0) ? $urandom : mq[j].pnpc;
            wb_trap  = ($urandom_range(0, 31) == 0);
         end else if ($urandom_range(0, 7) == 0) begin
            wb_valid = 1'b1;
            wb_dest  = tag_t'($urandom);
            wb_npc   = $urandom;
            wb_trap  = 1'($urandom_range(0, 1));
         end
         cmt_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
         exp_cv = m_cmt_valid();
         n_tests++; if (disp_ready !== (mq.size() < ROB_SIZE && !m_flush)) begin n_fail++; $display("FAIL rnd_disp_ready@%0d: got %b expected %b", c, disp_ready, mq.size() < ROB_SIZE && !m_flush); end
         n_tests++; if (disp_dest !== m_tail) begin n_fail++; $display("FAIL rnd_disp_dest@%0d: got %h expected %h", c, disp_dest, m_tail); end
         n_tests++; if (empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_empty@%0d: got %b expected %b", c, empty, mq.size() == 0); end
         n_tests++; if (flush !== m_flush) begin n_fail++; $display("FAIL rnd_flush@%0d: got %b expected %b", c, flush, m_flush); end
         if (m_flush) begin
            n_tests++; if (flush_pc !== m_flush_pc) begin n_fail++; $display("FAIL rnd_flush_pc@%0d: got %h expected %h", c, flush_pc, m_flush_pc); end
         end
         n_tests++; if (cmt_valid !== exp_cv) begin n_fail++; $display("FAIL rnd_cmt_valid@%0d: got %b expected %b", c, cmt_valid, exp_cv); end
         if (exp_cv) begin
            h = m_head_view();
            n_tests++; if (cmt_pc !== h.pc) begin n_fail++; $display("FAIL rnd_cmt_pc@%0d: got %h expected %h", c, cmt_pc, h.pc); end
            n_tests++; if (cmt_rd !== h.rd) begin n_fail++; $display("FAIL rnd_cmt_rd@%0d: got %h expected %h", c, cmt_rd, h.rd); end
            n_tests++; if (cmt_inst !== h.inst) begin n_fail++; $display("FAIL rnd_cmt_inst@%0d: got %h expected %h", c, cmt_inst, h.inst); end
            n_tests++; if (cmt_trap !== h.trap) begin n_fail++; $display("FAIL rnd_cmt_trap@%0d: got %b expected %b", c, cmt_trap, h.trap); end
            n_tests++; if (cmt_cause !== h.cause) begin n_fail++; $display("FAIL rnd_cmt_cause@%0d: got %h expected %h", c, cmt_cause, h.cause); end
            if (h.wbd) begin
               n_tests++; if (cmt_result !== h.result) begin n_fail++; $display("FAIL rnd_cmt_result@%0d: got %h expected %h", c, cmt_result, h.result); end
               n_tests++; if (cmt_npc !== h.npc) begin n_fail++; $display("FAIL rnd_cmt_npc@%0d: got %h expected %h", c, cmt_npc, h.npc); end
            end
         end
         advance();
      end
      idle_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill_empty();
      test_wrap();
      test_mispredict();
      test_trap_dispatch();
      test_simultaneous();
      test_reset_mid();
      test_random(2000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
